// File: rtl/jk_ctrl_pkg.sv
// Shared encodings and helpers for the JK flop-bank command controller.
package jk_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_RST  = 2'b01,
    OP_SET  = 2'b10,
    OP_TGL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_CHECK = 2'b10
  } state_e;

  localparam int ERR_CNT_W = 8;

  // Returns {J,K} for one flop under the given operation.
  function automatic logic [1:0] op_to_jk(input op_e op);
    logic [1:0] jk;
    case (op)
      OP_RST:  jk = 2'b01;
      OP_SET:  jk = 2'b10;
      OP_TGL:  jk = 2'b11;
      default: jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_bank_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, with wrap.
module rr_arbiter
  import jk_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [PTR_W-1:0] gnt_idx
);

  logic [PTR_W:0] w_cand;

  // Scan from the farthest offset down so the closest hit to ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_cand    = '0;
    for (int o = N_REQ - 1; o >= 0; o--) begin
      w_cand = {1'b0, ptr} + (PTR_W+1)'(o);
      if (w_cand >= (PTR_W+1)'(N_REQ)) begin
        w_cand = w_cand - (PTR_W+1)'(N_REQ);
      end
      if (req[w_cand[PTR_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = w_cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Round-robin command controller: issues one J/K pulse to a masked flop subset,
// reads the bank back one cycle later and acknowledges the requester.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int N_FF  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [N_REQ*N_FF-1:0]  req_mask,
  input  logic [N_FF-1:0]        q,
  output logic [N_FF-1:0]        j,
  output logic [N_FF-1:0]        k,
  output logic [N_REQ-1:0]       ack,
  output logic                   err,
  output logic                   busy,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam int PTR_W = $clog2(N_REQ);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     r_gnt_idx;
  op_e                  r_op;
  logic [N_FF-1:0]      r_mask;
  logic [N_FF-1:0]      r_q_snap;
  logic [N_FF-1:0]      r_j;
  logic [N_FF-1:0]      r_k;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic                 w_arb_vld;
  logic [PTR_W-1:0]     w_arb_idx;
  op_e                  w_sel_op;
  logic [N_FF-1:0]      w_sel_mask;
  logic [1:0]           w_sel_jk;
  logic [PTR_W-1:0]     w_ptr_nxt;
  logic [N_FF-1:0]      w_exp;
  logic [N_REQ-1:0]     w_ack;
  logic                 w_err;
  logic                 w_busy;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (req),
    .ptr       (r_ptr),
    .gnt_valid (w_arb_vld),
    .gnt_idx   (w_arb_idx)
  );

  assign w_sel_op   = op_e'(req_op[2*int'(w_arb_idx) +: 2]);
  assign w_sel_mask = req_mask[int'(w_arb_idx)*N_FF +: N_FF];
  assign w_sel_jk   = op_to_jk(w_sel_op);
  assign w_ptr_nxt  = (r_gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = '0;
    w_err       = 1'b0;
    w_busy      = 1'b0;
    w_exp       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_vld) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_busy      = 1'b1;
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_busy = 1'b1;
        case (r_op)
          OP_SET:  w_exp = r_mask;
          OP_RST:  w_exp = '0;
          OP_TGL:  w_exp = ~r_q_snap;
          default: w_exp = r_q_snap;
        endcase
        w_ack[r_gnt_idx] = 1'b1;
        w_err            = |((q ^ w_exp) & r_mask);
        w_state_nxt      = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ack/err are gated by rst so a reset during CHECK aborts cleanly.
  assign ack     = rst ? '0 : w_ack;
  assign err     = rst ? 1'b0 : w_err;
  assign busy    = w_busy;
  assign j       = r_j;
  assign k       = r_k;
  assign err_cnt = r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_arb_vld) begin
            r_j <= {N_FF{w_sel_jk[1]}} & w_sel_mask;
            r_k <= {N_FF{w_sel_jk[0]}} & w_sel_mask;
          end else begin
            r_j <= '0;
            r_k <= '0;
          end
        end
        S_ISSUE: begin
          r_j   <= '0;
          r_k   <= '0;
          r_ptr <= w_ptr_nxt;
        end
        S_CHECK: begin
          if (w_err) begin
            r_err_cnt <= sat_inc(r_err_cnt);
          end
        end
        default: begin
          r_j <= '0;
          r_k <= '0;
        end
      endcase
    end
  end

  // Grant-time latches and the pre-update readback snapshot carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_arb_vld) begin
      r_gnt_idx <= w_arb_idx;
      r_op      <= w_sel_op;
      r_mask    <= w_sel_mask;
    end
    if (r_state == S_ISSUE) begin
      r_q_snap <= q;
    end
  end

endmodule
